count_updn_mod: RTL and testbench
=================================

// Module: count_updn_mod
// PURPOSE
// - Parametrised up/down modulo counter; next generation of the team's fixed 4-bit free-running up counter.
// - Adds width/modulus parameters, enable, direction, parallel load, clear, wrap pulse and one-shot mode.
// - General-purpose timebase and event counter for the cocotb quickstart designs and the blocks built on them.
// PARAMETERS
// - WIDTH    4   counter width in bits; legal range 1..32
// - MAX_VAL  15  terminal value; count range 0..MAX_VAL; must satisfy MAX_VAL <= 2**WIDTH-1
// - ONESHOT  0   0: free-running with wrap; 1: stop at the terminal value and assert done
// PORTS
// - clk       in   1      clock; all state changes on the rising edge
// - reset     in   1      synchronous, active-high reset
// - en        in   1      count enable; one step per enabled cycle
// - dir       in   1      1 = count up, 0 = count down
// - clear     in   1      synchronous clear to 0
// - load      in   1      parallel load strobe
// - load_val  in   WIDTH  value to load
// - sat       in   1      saturate instead of wrap; port exists only with COUNT_UPDN_SAT_EN
// - count     out  WIDTH  current count (registered)
// - wrap      out  1      one-cycle pulse, registered; high alongside the wrapped count value
// - done      out  1      one-shot finished, registered; always 0 when ONESHOT=0
// BEHAVIOUR
// - Reset: count=0, wrap=0, done=0. Reset is synchronous, active-high; clock is clk. Reset has top priority and aborts any operation.
// - Priority each cycle: reset > clear > load > en. Lower-priority requests in the same cycle are ignored.
// - clear: count<=0, wrap<=0, done<=0.
// - load: count<=min(load_val, MAX_VAL); wrap<=0; done<=0. An out-of-range value clamps to MAX_VAL.
// - en=1, dir=1: count<MAX_VAL -> count+1. count==MAX_VAL -> count<=0, wrap<=1.
// - en=1, dir=0: count>0 -> count-1. count==0 -> count<=MAX_VAL, wrap<=1.
// - en=0: count holds; wrap<=0.
// - wrap is high for exactly one cycle per wrap event. Back-to-back wraps (e.g. MAX_VAL=0) keep it high on every enabled cycle.
// - dir may change on any cycle; the step uses the dir value sampled on that edge.
// - Arithmetic uses WIDTH+1-bit intermediates. No implicit 2**WIDTH overflow is ever used as the wrap mechanism.
// - ONESHOT=1, two-state FSM:
//   - RUN->DONE: on the enabled step that would wrap. count holds its bound (MAX_VAL up, 0 down), done<=1, wrap stays 0.
//   - DONE: en is ignored; count and done=1 hold.
//   - DONE->RUN: on clear or load only.
//   - reset returns the FSM to RUN.
// - Latency: every input takes effect on count/wrap/done at the next rising edge. No combinational path from input to output.
// CONFIGURATION
// - COUNT_UPDN_SAT_EN defined:
//   - sat port exists.
//   - sat=1 with ONESHOT=0: a step past a bound holds count at the bound; wrap stays 0.
//   - sat=0: wraps normally.
//   - ONESHOT=1 overrides sat.
// - COUNT_UPDN_SAT_EN undefined: no sat port; the counter always wraps (or one-shots). Logic is otherwise identical.
// TESTING
// - Reset: assert reset 2 cycles with en=1, load=1 -> count=0, wrap=0, done=0. Release -> count increments from 0.
// - Up wrap, MAX_VAL=9, dir=1, en=1 for 12 cycles -> count 1..9,0,1,2. wrap=1 only in the cycle count=0.
// - Down wrap, MAX_VAL=9, start 1, dir=0 -> count 0,9,8. wrap=1 with count=9. Toggle en -> count holds when en=0.
// - Load clamp and priority: load_val=15 with MAX_VAL=9 -> count=9. clear+load+en same cycle -> count=0.
// - ONESHOT=1, MAX_VAL=5, up from 0 -> reaches 5, done=1 and holds for 10 cycles. load_val=2 -> done=0, counts 3,4,5.
// - COUNT_UPDN_SAT_EN, sat=1, up at 9 -> count stays 9, wrap=0. Reset mid-run at count=7 -> count=0 next cycle.

Source files
------------

// File: rtl/count_updn_mod.sv
// count_updn_mod: parametrised up/down modulo counter with load, clear, wrap pulse, one-shot.
// Define COUNT_UPDN_SAT_EN to add the sat port (hold at bound instead of wrapping).
module count_updn_mod #(
  parameter int WIDTH   = 4,
  parameter int MAX_VAL = 15,
  parameter int ONESHOT = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             dir,
  input  logic             clear,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
`ifdef COUNT_UPDN_SAT_EN
  input  logic             sat,
`endif
  output logic [WIDTH-1:0] count,
  output logic             wrap,
  output logic             done
);

  localparam logic [WIDTH:0]   LP_MAX_X = (WIDTH+1)'(MAX_VAL);
  localparam logic [WIDTH-1:0] LP_MAX   = WIDTH'(MAX_VAL);

  typedef enum logic {
    S_RUN  = 1'b0,
    S_DONE = 1'b1
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_count;
  logic             r_wrap;
  logic             r_done;

  logic             w_sat;
  logic [WIDTH:0]   w_cnt_x;
  logic [WIDTH:0]   w_inc;
  logic [WIDTH:0]   w_dec;
  logic [WIDTH:0]   w_ld_x;
  logic [WIDTH-1:0] w_ld_val;
  logic             w_past_max;
  logic             w_past_zero;
  logic             w_bound;

`ifdef COUNT_UPDN_SAT_EN
  assign w_sat = sat;
`else
  assign w_sat = 1'b0;
`endif

  // Bounds are detected in WIDTH+1 bits rather than relying on rollover.
  assign w_cnt_x     = {1'b0, r_count};
  assign w_inc       = w_cnt_x + 1'b1;
  assign w_dec       = w_cnt_x - 1'b1;
  assign w_past_max  = (w_inc > LP_MAX_X);
  assign w_past_zero = w_dec[WIDTH];
  assign w_bound     = dir ? w_past_max : w_past_zero;

  assign w_ld_x   = {1'b0, load_val};
  assign w_ld_val = (w_ld_x > LP_MAX_X) ? LP_MAX : load_val;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_RUN;
      r_count <= '0;
      r_wrap  <= 1'b0;
      r_done  <= 1'b0;
    end else if (clear) begin
      r_state <= S_RUN;
      r_count <= '0;
      r_wrap  <= 1'b0;
      r_done  <= 1'b0;
    end else if (load) begin
      r_state <= S_RUN;
      r_count <= w_ld_val;
      r_wrap  <= 1'b0;
      r_done  <= 1'b0;
    end else if (r_state == S_DONE) begin
      r_wrap  <= 1'b0;
    end else if (en) begin
      if (!w_bound) begin
        r_count <= dir ? w_inc[WIDTH-1:0] : w_dec[WIDTH-1:0];
        r_wrap  <= 1'b0;
      end else if (ONESHOT != 0) begin
        r_state <= S_DONE;
        r_done  <= 1'b1;
        r_wrap  <= 1'b0;
      end else if (w_sat) begin
        r_wrap  <= 1'b0;
      end else begin
        r_count <= dir ? '0 : LP_MAX;
        r_wrap  <= 1'b1;
      end
    end else begin
      r_wrap  <= 1'b0;
    end
  end

  assign count = r_count;
  assign wrap  = r_wrap;
  assign done  = r_done;

endmodule

// File: tb/tb_count_updn_mod.sv
// Scoreboard bench for count_updn_mod: three configurations share stimulus,
// an integer reference model queues expectations, a monitor pops and compares.
module tb_count_updn_mod;

  typedef struct {
    int c;
    bit w;
    bit d;
  } mstate_t;

`ifdef COUNT_UPDN_SAT_EN
  localparam bit SAT_EN = 1'b1;
`else
  localparam bit SAT_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       en = 1'b0;
  logic       dir = 1'b1;
  logic       clear = 1'b0;
  logic       load = 1'b0;
  logic [3:0] load_val = '0;
  logic       sat_i = 1'b0;

  logic [3:0] c0, c1, c2;
  logic       w0, w1, w2;
  logic       d0, d1, d2;

  int n_vec = 0;
  int n_err = 0;

  mstate_t m0, m1, m2;
  mstate_t q0[$], q1[$], q2[$];

  always #5 clk = ~clk;

  count_updn_mod #(.WIDTH(4), .MAX_VAL(9), .ONESHOT(0)) u0 (
    .clk(clk), .reset(reset), .en(en), .dir(dir), .clear(clear),
    .load(load), .load_val(load_val),
`ifdef COUNT_UPDN_SAT_EN
    .sat(sat_i),
`endif
    .count(c0), .wrap(w0), .done(d0));

  count_updn_mod #(.WIDTH(4), .MAX_VAL(5), .ONESHOT(1)) u1 (
    .clk(clk), .reset(reset), .en(en), .dir(dir), .clear(clear),
    .load(load), .load_val(load_val),
`ifdef COUNT_UPDN_SAT_EN
    .sat(sat_i),
`endif
    .count(c1), .wrap(w1), .done(d1));

  count_updn_mod #(.WIDTH(4), .MAX_VAL(0), .ONESHOT(0)) u2 (
    .clk(clk), .reset(reset), .en(en), .dir(dir), .clear(clear),
    .load(load), .load_val(load_val),
`ifdef COUNT_UPDN_SAT_EN
    .sat(sat_i),
`endif
    .count(c2), .wrap(w2), .done(d2));

  function automatic mstate_t nxt(mstate_t s, int mx, bit os,
                                  bit rst, bit clr, bit ld, int lv,
                                  bit e, bit dr, bit st);
    mstate_t n;
    int t;
    n = s;
    n.w = 1'b0;
    if (rst || clr) begin
      n.c = 0;
      n.d = 1'b0;
    end else if (ld) begin
      n.c = (lv > mx) ? mx : lv;
      n.d = 1'b0;
    end else if (!s.d && e) begin
      t = dr ? s.c + 1 : s.c - 1;
      if (t >= 0 && t <= mx) begin
        n.c = t;
      end else if (os) begin
        n.d = 1'b1;
      end else if (!(st && SAT_EN)) begin
        n.c = dr ? 0 : mx;
        n.w = 1'b1;
      end
    end
    return n;
  endfunction

  task automatic cyc(bit rst, bit clr, bit ld, int lv,
                     bit e, bit dr, bit st);
    @(negedge clk);
    reset = rst;
    clear = clr;
    load = ld;
    load_val = 4'(lv);
    en = e;
    dir = dr;
    sat_i = st;
    m0 = nxt(m0, 9, 1'b0, rst, clr, ld, lv, e, dr, st);
    m1 = nxt(m1, 5, 1'b1, rst, clr, ld, lv, e, dr, st);
    m2 = nxt(m2, 0, 1'b0, rst, clr, ld, lv, e, dr, st);
    q0.push_back(m0);
    q1.push_back(m1);
    q2.push_back(m2);
  endtask

  task automatic cmp(string nm, int ac, bit aw, bit ad, mstate_t ex);
    n_vec++;
    if (ac != ex.c || aw != ex.w || ad != ex.d) begin
      n_err++;
      $display("FAIL %s @%0t: count=%0d wrap=%0b done=%0b, expected %0d %0b %0b",
               nm, $time, ac, aw, ad, ex.c, ex.w, ex.d);
    end
  endtask

  task automatic chk(string nm, int act, int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  task automatic settle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    mstate_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q0.size() > 0) begin
        e = q0.pop_front();
        cmp("u0_mod9", int'(c0), w0, d0, e);
      end
      if (q1.size() > 0) begin
        e = q1.pop_front();
        cmp("u1_oneshot5", int'(c1), w1, d1, e);
      end
      if (q2.size() > 0) begin
        e = q2.pop_front();
        cmp("u2_mod0", int'(c2), w2, d2, e);
      end
    end
  end

  initial begin
    m0 = '{c: 0, w: 1'b0, d: 1'b0};
    m1 = m0;
    m2 = m0;

    // reset held with en and load active
    cyc(1, 0, 1, 5, 1, 1, 0);
    cyc(1, 0, 1, 5, 1, 1, 0);
    settle();
    chk("reset_count", int'(c0), 0);
    chk("reset_done", int'(d1), 0);

    // up count through the wrap
    repeat (9) cyc(0, 0, 0, 0, 1, 1, 0);
    settle();
    chk("up_at_max", int'(c0), 9);
    cyc(0, 0, 0, 0, 1, 1, 0);
    settle();
    chk("up_wrap_count", int'(c0), 0);
    chk("up_wrap_pulse", int'(w0), 1);
    repeat (2) cyc(0, 0, 0, 0, 1, 1, 0);

    // down through zero, then en toggling
    cyc(0, 0, 1, 1, 0, 0, 0);
    repeat (2) cyc(0, 0, 0, 0, 1, 0, 0);
    settle();
    chk("down_wrap_count", int'(c0), 9);
    chk("down_wrap_pulse", int'(w0), 1);
    for (int i = 0; i < 6; i++) cyc(0, 0, 0, 0, i[0], 0, 0);

    // load clamp and priority
    cyc(0, 0, 1, 15, 1, 1, 0);
    settle();
    chk("load_clamp", int'(c0), 9);
    cyc(0, 1, 1, 7, 1, 1, 0);
    settle();
    chk("clear_prio", int'(c0), 0);

    // one-shot run to completion, then reload
    repeat (16) cyc(0, 0, 0, 0, 1, 1, 0);
    settle();
    chk("oneshot_done", int'(d1), 1);
    chk("oneshot_hold", int'(c1), 5);
    cyc(0, 0, 1, 2, 0, 1, 0);
    repeat (4) cyc(0, 0, 0, 0, 1, 1, 0);
    // one-shot downward
    cyc(0, 0, 1, 2, 0, 0, 0);
    repeat (5) cyc(0, 0, 0, 0, 1, 0, 0);

    // saturation at the top bound
    cyc(0, 0, 1, 9, 0, 1, 1);
    repeat (3) cyc(0, 0, 0, 0, 1, 1, 1);
    cyc(0, 0, 1, 0, 0, 0, 1);
    repeat (2) cyc(0, 0, 0, 0, 1, 0, 1);

    // reset mid-run
    cyc(0, 0, 1, 7, 0, 1, 0);
    cyc(1, 0, 0, 0, 1, 1, 0);
    settle();
    chk("midrun_reset", int'(c0), 0);

    // randomized traffic
    for (int i = 0; i < 500; i++) begin
      cyc($urandom_range(0, 49) == 0,
          $urandom_range(0, 19) == 0,
          $urandom_range(0, 9) == 0,
          int'($urandom_range(0, 15)),
          $urandom_range(0, 3) != 0,
          $urandom_range(0, 1) == 1,
          $urandom_range(0, 1) == 1);
    end

    repeat (2) @(posedge clk);
    #2;
    n_vec++;
    if (q0.size() + q1.size() + q2.size() != 0) begin
      n_err++;
      $display("FAIL drain: %0d expectations left, expected 0",
               q0.size() + q1.size() + q2.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
